// File: rtl/seg_display_arbiter_if.sv
// Bus between the hex-digit requesters and the seg_display_arbiter.
// The requester side (master) drives req/data; the arbiter (slave) drives the rest.
interface seg_display_arbiter_if;
    logic [3:0]  req;
    logic [15:0] data;
    logic [7:0]  seg;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [1:0]  owner;
    logic        busy;

    modport master (
        output req, data,
        input  seg, gnt, done, owner, busy
    );

    modport slave (
        input  req, data,
        output seg, gnt, done, owner, busy
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that shares one 7-segment digit among four requesters.
// Each grant shows the winner's latched hex nibble for DWELL cycles, then one
// blank cycle, then one dash cycle before the next grant can start.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | dash shown, looking for the next requester in rotation order
// SHOW  | owner's latched nibble shown; dwell counter runs down to 0
// GAP   | blank digit for one cycle between grants
module seg_display_arbiter #(
    parameter int DWELL = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    seg_display_arbiter_if.slave  bus
);
    localparam int NREQ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [7:0] cnt;
    logic [3:0] nib;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;

    logic [7:0] seg_c;
    logic [3:0] gnt_c;
    logic [3:0] done_c;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // First active requester searching from ptr upward, wrapping mod 4.
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // State, rotation pointer, owner, dwell down-counter and latched nibble.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= 2'd0;
            owner <= 2'd0;
            cnt   <= 8'd0;
            nib   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_SHOW;
                        owner <= pick;
                        nib   <= bus.data[{pick, 2'b00} +: 4];
                        cnt   <= DWELL_M1;
                    end
                end
                ST_SHOW: begin
                    // A dropped request ends the grant early, exactly like terminal count.
                    if (!bus.req[owner] || cnt == 8'd0) begin
                        state <= ST_GAP;
                        ptr   <= owner + 2'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Display, grant and completion outputs decoded from the current state.
    always_comb begin
        seg_c  = 8'h40;
        gnt_c  = 4'b0000;
        done_c = 4'b0000;
        case (state)
            ST_SHOW: begin
                seg_c = {1'b0, hex7(nib)};
                gnt_c = 4'b0001 << owner;
                // A grant cut by reset on its final cycle must not report completion.
                if (cnt == 8'd0 && bus.req[owner] && !reset) begin
                    done_c = 4'b0001 << owner;
                end
            end
            ST_GAP: begin
                seg_c = 8'h00;
            end
            default: begin
                seg_c = 8'h40;
            end
        endcase
    end

    assign bus.seg   = seg_c;
    assign bus.gnt   = gnt_c;
    assign bus.done  = done_c;
    assign bus.owner = owner;
    assign bus.busy  = (state != ST_IDLE);
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: a transaction-level requester model
// predicts each grant (winner, digit, length, completion) into a queue, and a
// monitor checks the DUT outputs cycle by cycle against the popped grant.
module tb_seg_display_arbiter;
    localparam int DWELL = 4;

    typedef struct {
        logic [1:0] owner;
        logic [6:0] seg;
        int         len;
        bit         has_done;
        bit         cut;
        int         start;
    } exp_t;

    logic clk_2;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;

    logic [1:0] m_ptr;
    exp_t       q[$];

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(.DWELL(DWELL)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    // One arbitration episode starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic ep(input logic [3:0] r, input logic [15:0] d, input int abort_at,
                      input int reset_at, input bit scramble);
        exp_t       e;
        logic [1:0] w;
        logic [1:0] cand;
        logic [3:0] rr;
        bit         fnd;
        bus.req  = r;
        bus.data = d;
        if (r == 4'b0000) begin
            step();
            return;
        end
        fnd = 1'b0;
        w   = m_ptr;
        for (int i = 0; i < 4; i++) begin
            cand = m_ptr + 2'(i);
            if (!fnd && r[cand]) begin
                fnd = 1'b1;
                w   = cand;
            end
        end
        e.owner    = w;
        e.seg      = hex_tab[d[int'(w) * 4 +: 4]];
        e.has_done = (abort_at == 0 && reset_at == 0);
        e.cut      = (abort_at == 0 && reset_at > 0);
        e.len      = (abort_at > 0) ? abort_at : (e.cut ? reset_at : DWELL);
        e.start    = cyc + 1;
        q.push_back(e);
        step();
        for (int k = 1; k <= e.len; k++) begin
            rr    = scramble ? 4'($urandom) : r;
            rr[w] = (abort_at != k);
            bus.req = rr;
            if (scramble) bus.data = 16'($urandom);
            if (e.cut && reset_at == k) reset = 1'b1;
            step();
        end
        if (e.cut) begin
            reset   = 1'b0;
            m_ptr   = 2'd0;
            bus.req = 4'b0000;
        end else begin
            m_ptr    = w + 2'd1;
            bus.req  = 4'($urandom);
            bus.data = 16'($urandom);
            step();
            bus.req = 4'b0000;
        end
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        bus.req = 4'b0000;
        repeat (n) step();
        reset = 1'b0;
        m_ptr = 2'd0;
    endtask

    bit         in_grant;
    bit         prev_reset;
    int         kk;
    exp_t       cur;
    logic [1:0] last_owner;

    // Monitor: pops a predicted grant when gnt rises and checks every cycle of it.
    always @(negedge clk_2) begin
        if (mon_en) begin
            if (prev_reset) last_owner = 2'd0;
            if (bus.gnt != 4'b0000) begin
                if (!in_grant) begin
                    if (q.size() == 0) begin
                        chk("unexpected_grant", {28'd0, bus.gnt}, 32'd0);
                        cur.owner = 2'd0; cur.seg = 7'h00; cur.len = 0;
                        cur.has_done = 1'b0; cur.cut = 1'b0; cur.start = cyc;
                    end else begin
                        cur = q.pop_front();
                        chk("grant_cycle", cyc, cur.start);
                    end
                    in_grant = 1'b1;
                    kk = 0;
                end
                kk++;
                chk("gnt", {28'd0, bus.gnt}, 32'(4'b0001 << cur.owner));
                chk("seg_show", {24'd0, bus.seg}, {25'd0, cur.seg});
                chk("owner_show", {30'd0, bus.owner}, {30'd0, cur.owner});
                chk("busy_show", {31'd0, bus.busy}, 32'd1);
                chk("done_show", {28'd0, bus.done},
                    (kk == cur.len && cur.has_done) ? 32'(4'b0001 << cur.owner) : 32'd0);
                if (kk > cur.len) chk("grant_too_long", kk, cur.len);
            end else begin
                if (in_grant) begin
                    in_grant = 1'b0;
                    chk("grant_len", kk, cur.len);
                    chk("seg_after", {24'd0, bus.seg}, cur.cut ? 32'h40 : 32'h00);
                    chk("busy_after", {31'd0, bus.busy}, cur.cut ? 32'd0 : 32'd1);
                    last_owner = cur.cut ? 2'd0 : cur.owner;
                end else begin
                    chk("seg_idle", {24'd0, bus.seg}, 32'h40);
                    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
                end
                chk("done_idle", {28'd0, bus.done}, 32'd0);
                chk("owner_hold", {30'd0, bus.owner}, {30'd0, last_owner});
            end
        end
        prev_reset = reset;
    end

    // Stimulus: directed scenarios first, then randomized episodes.
    initial begin
        int ab;
        int rs;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        mon_en     = 1'b0;
        in_grant   = 1'b0;
        prev_reset = 1'b0;
        kk         = 0;
        last_owner = 2'd0;
        m_ptr      = 2'd0;
        reset      = 1'b1;
        bus.req    = 4'b0000;
        bus.data   = 16'h0000;
        step();
        mon_en = 1'b1;
        do_reset(2);
        step();

        // Single request showing 'A'.
        ep(4'b0001, 16'h000A, 0, 0, 1'b0);
        // Fairness from reset with all four requesting.
        do_reset(1);
        repeat (5) ep(4'b1111, 16'($urandom), 0, 0, 1'b0);
        // Rotation: grant 1 then 0011 goes to requester 0.
        ep(4'b1111, 16'h1234, 0, 0, 1'b0);
        ep(4'b0011, 16'h5678, 0, 0, 1'b0);
        // Abort of requester 2 in its second SHOW cycle.
        ep(4'b0100, 16'h0C00, 2, 0, 1'b0);
        // Next grant proves ptr moved to 3.
        ep(4'b1111, 16'hE000, 0, 0, 1'b0);
        // Abort on the final SHOW cycle.
        ep(4'b0001, 16'h0005, DWELL, 0, 1'b0);
        // Reset in the second SHOW cycle, then 1001 goes to requester 0.
        ep(4'b0010, 16'h00B0, 0, 2, 1'b0);
        ep(4'b1001, 16'h7001, 0, 0, 1'b0);
        // Data churn during a grant to requester 1 showing '3'.
        ep(4'b0010, 16'h0030, 0, 0, 1'b1);
        ep(4'b0000, 16'h0000, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DWELL)) : 0;
            rs = (ab == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, DWELL - 1)) : 0;
            ep(4'($urandom_range(0, 15)), 16'($urandom), ab, rs, 1'($urandom_range(0, 1)));
        end

        repeat (3) step();
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
